// File: rtl/instr_encoder_writer.sv
// instr_encoder_writer: packs decoder-format fields into 32-bit words
// and streams them through a small FIFO into instruction memory.
module instr_encoder_writer #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 27,
  parameter longint ADDR_LIMIT = 2**27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [3:0]        in_instr_op,
  input  logic [3:0]        in_alu_op,
  input  logic [3:0]        in_areg,
  input  logic [3:0]        in_breg,
  input  logic [3:0]        in_dreg,
  input  logic [31:0]       in_const,
  input  logic              in_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  input  logic              mem_busy,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic [ADDR_W-1:0] words_written,
  output logic              enc_err,
  input  logic              err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(ADDR_LIMIT - 1);

  logic [31:0] word;
  logic        ovf;

  always_comb begin
    word = '0;
    ovf  = 1'b0;
    unique case (in_fmt)
      2'd0: word = {in_instr_op, 1'b0, in_alu_op,
                    11'b0, in_areg, in_breg, in_dreg};
      2'd1: begin
        word = {in_instr_op, 1'b1, in_alu_op,
                in_const[10:0], in_areg, 4'b0, in_dreg};
        ovf  = !(&in_const[31:10] || ~|in_const[31:10]);
      end
      2'd2: begin
        word = {in_instr_op, in_const[15:0],
                in_areg, 4'b0, in_dreg};
        ovf  = !(&in_const[31:15] || ~|in_const[31:15]);
      end
      2'd3: begin
        word = {in_instr_op, in_const[26:0], in_oe};
        ovf  = !(&in_const[31:26] || ~|in_const[31:26]);
      end
    endcase
  end

  logic [31:0]   store [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full     = count == CW'(DEPTH);
  assign empty    = count == '0;
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = !empty && !mem_busy;
  assign mem_we   = !empty;
  assign mem_data = empty ? '0 : store[rptr];

  always_ff @(posedge clk) begin
    if (push) store[wptr] <= word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] base;

  assign mem_addr = cnt;

  // a load overrides the counter step but the popped word still counts
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      base          <= '0;
      words_written <= '0;
    end else begin
      if (pop) words_written <= words_written + 1'b1;
      if (addr_load) begin
        base <= addr_base;
        cnt  <= addr_base;
      end else if (pop) begin
        cnt <= (cnt == LAST) ? base : cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)             enc_err <= 1'b0;
    else if (push && ovf)  enc_err <= 1'b1;
    else if (err_clr)      enc_err <= 1'b0;
  end

endmodule
